// File: rtl/boot_loader.sv
// Program loader: holds the core in reset, streams a host image into memory at LOAD_BASE, then releases the core.
// Optional readback check of the image is compiled in with BOOT_LOADER_VERIFY_EN.
module boot_loader #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MEM_DEPTH  = 65536,
    parameter int unsigned LOAD_BASE  = 32'h0200
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] len,
    input  logic                  host_valid,
    input  logic [DATA_WIDTH-1:0] host_data,
    output logic                  host_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_din,
    input  logic                  core_we,
    output logic                  core_reset_n,
    output logic                  trigger_program,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned MAX_LEN = MEM_DEPTH - LOAD_BASE;
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(LOAD_BASE);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_VERIFY  = 3'd2,
        S_RELEASE = 3'd3,
        S_RUN     = 3'd4,
        S_ERROR   = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] len_q, len_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
    logic [ADDR_WIDTH-1:0] vcnt_q, vcnt_d;
    logic [DATA_WIDTH-1:0] chk_q, chk_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;
    logic                  mem_we_q, mem_we_d;
    logic                  host_ready_q, host_ready_d;
    logic                  core_rst_n_q, core_rst_n_d;
    logic                  trig_q, trig_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  xfer_c;
    logic                  too_long_c;

    assign xfer_c     = (state_q == S_LOAD) && host_valid && host_ready_q;
    assign too_long_c = 32'(len) > MAX_LEN;

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            count_q      <= '0;
            sum_q        <= '0;
            vcnt_q       <= '0;
            chk_q        <= '0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            mem_we_q     <= 1'b0;
            host_ready_q <= 1'b0;
            core_rst_n_q <= 1'b0;
            trig_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            count_q      <= count_d;
            sum_q        <= sum_d;
            vcnt_q       <= vcnt_d;
            chk_q        <= chk_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            mem_we_q     <= mem_we_d;
            host_ready_q <= host_ready_d;
            core_rst_n_q <= core_rst_n_d;
            trig_q       <= trig_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    // Next-state and datapath counters
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        count_d = count_q;
        sum_d   = sum_q;
        vcnt_d  = vcnt_q;
        chk_d   = chk_q;
        case (state_q)
            S_IDLE, S_RUN, S_ERROR: begin
                if (start) begin
                    if (too_long_c) begin
                        state_d = S_ERROR;
                    end else if (len == '0) begin
                        state_d = S_RELEASE;
                    end else begin
                        len_d   = len;
                        count_d = '0;
                        sum_d   = '0;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (xfer_c) begin
                    count_d = ADDR_WIDTH'(count_q + 1'b1);
                    sum_d   = DATA_WIDTH'(sum_q + host_data);
                end
                // count==len means the final write is on the bus this cycle
                if (count_q == len_q) begin
`ifdef BOOT_LOADER_VERIFY_EN
                    vcnt_d  = '0;
                    chk_d   = '0;
                    state_d = S_VERIFY;
`else
                    state_d = S_RELEASE;
`endif
                end
            end
`ifdef BOOT_LOADER_VERIFY_EN
            S_VERIFY: begin
                // Read data lags the address by one cycle, hence len+1 cycles here
                vcnt_d = ADDR_WIDTH'(vcnt_q + 1'b1);
                if (vcnt_q != '0) begin
                    chk_d = DATA_WIDTH'(chk_q + mem_dout);
                end
                if (vcnt_q == len_q) begin
                    state_d = (DATA_WIDTH'(chk_q + mem_dout) == sum_q) ? S_RELEASE : S_ERROR;
                end
            end
`endif
            S_RELEASE: state_d = S_RUN;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output register inputs, decoded from the next state
    always_comb begin
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        mem_we_d     = xfer_c;
        host_ready_d = (state_d == S_LOAD) && (count_d < len_d);
        core_rst_n_d = (state_d == S_RUN);
        trig_d       = (state_d == S_RUN) && (state_q != S_RUN);
        busy_d       = (state_d == S_LOAD) || (state_d == S_VERIFY) || (state_d == S_RELEASE);
        done_d       = (state_d == S_RUN);
        error_d      = (state_d == S_ERROR);
        if (xfer_c) begin
            mem_addr_d = BASE + count_q;
            mem_din_d  = host_data;
        end
`ifdef BOOT_LOADER_VERIFY_EN
        if (state_d == S_VERIFY) begin
            mem_addr_d = BASE + vcnt_d;
        end
`endif
    end

`ifndef BOOT_LOADER_VERIFY_EN
    logic unused_ok;
    assign unused_ok = ^{mem_dout, sum_q, vcnt_q, chk_q};
`endif

    // Core owns the memory port only while running
    assign mem_addr        = (state_q == S_RUN) ? core_addr : mem_addr_q;
    assign mem_din         = (state_q == S_RUN) ? core_din  : mem_din_q;
    assign mem_we          = (state_q == S_RUN) ? core_we   : mem_we_q;
    assign host_ready      = host_ready_q;
    assign core_reset_n    = core_rst_n_q;
    assign trigger_program = trig_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign error           = error_q;

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: expected memory writes are queued by stimulus and popped by a monitor.
module tb_boot_loader;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [15:0] len;
    logic        host_valid;
    logic [7:0]  host_data;
    logic        host_ready;
    logic [15:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_we;
    logic [7:0]  mem_dout;
    logic [15:0] core_addr;
    logic [7:0]  core_din;
    logic        core_we;
    logic        core_reset_n;
    logic        trigger_program;
    logic        busy;
    logic        done;
    logic        error;

    boot_loader dut (
        .clk(clk), .reset_n(reset_n), .start(start), .len(len),
        .host_valid(host_valid), .host_data(host_data), .host_ready(host_ready),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout),
        .core_addr(core_addr), .core_din(core_din), .core_we(core_we),
        .core_reset_n(core_reset_n), .trigger_program(trigger_program),
        .busy(busy), .done(done), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory; corrupt flips read data at 0201
    logic [7:0] mem [0:65535];
    logic       corrupt;
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_din;
        mem_dout <= mem[mem_addr] ^ ((corrupt && mem_addr == 16'h0201) ? 8'h5a : 8'h00);
    end

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t  exp_q[$];
    int   wr_cyc[$];
    int   n_vec, n_err, wr_cnt, trig_cnt, cyc;
    bit   sb_on;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic monitor();
        wr_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset_n && sb_on && mem_we && !core_reset_n) begin
                wr_cnt++;
                wr_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 32'(mem_addr), 32'hffff_ffff);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(mem_addr), 32'(e.a));
                    chk("wr_data", 32'(mem_din), 32'(e.d));
                end
            end
            if (trigger_program) begin
                trig_cnt++;
                chk("trig_core_rst", 32'(core_reset_n), 32'd1);
            end
        end
    endtask

    task automatic clear_stats();
        wr_cnt   = 0;
        trig_cnt = 0;
        wr_cyc.delete();
    endtask

    // Issue start and feed n bytes following the valid pattern (empty = always valid)
    task automatic load(input int n, input logic [7:0] b[$], input bit pat[$]);
        int  idx, p, guard;
        bit  hr;
        for (int i = 0; i < n; i++) begin
            wr_t w;
            w.a = 16'(16'h0200 + i);
            w.d = b[i];
            exp_q.push_back(w);
        end
        @(posedge clk); #1;
        start = 1'b1;
        len   = 16'(n);
        @(posedge clk); #1;
        start = 1'b0;
        idx = 0; p = 0; guard = 0;
        while (idx < n && guard < 200) begin
            host_valid = (pat.size() == 0) ? 1'b1 : pat[p % pat.size()];
            host_data  = b[idx];
            p++;
            @(negedge clk);
            hr = host_ready;
            @(posedge clk);
            if (host_valid && hr) idx++;
            #1;
            guard++;
        end
        host_valid = 1'b0;
        chk("bytes_fed", 32'(idx), 32'(n));
    endtask

    task automatic wait_end();
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!(done || error) && c < 40);
        chk("end_timeout", 32'(c < 40), 32'd1);
    endtask

    task automatic check_reset_outputs(input string nm);
        chk(nm, {25'd0, host_ready, mem_we, core_reset_n, trigger_program, busy, done, error}, 32'd0);
        chk({nm, "_addr"}, 32'(mem_addr), 32'd0);
        chk({nm, "_din"}, 32'(mem_din), 32'd0);
    endtask

    logic [7:0] img[$];
    logic [7:0] img5[$];
    bit         gap[$];
    bit         none[$];

    initial begin
        n_vec = 0; n_err = 0; cyc = 0; sb_on = 1'b1;
        clear_stats();
        reset_n = 1'b0; start = 1'b0; len = '0; host_valid = 1'b0; host_data = '0;
        core_addr = '0; core_din = '0; core_we = 1'b0; corrupt = 1'b0;
        img  = '{8'hA9, 8'h05, 8'h85, 8'h10};
        img5 = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
        gap  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        none = {};
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("reset_state");
        reset_n = 1'b1;

        // 4-byte load, host always valid
        load(4, img, none);
        wait_end();
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_core_rst", 32'(core_reset_n), 32'd1);
        repeat (3) @(negedge clk);
        chk("t1_trig_cnt", 32'(trig_cnt), 32'd1);
        chk("t1_trig_low", 32'(trigger_program), 32'd0);
        chk("t1_wr_cnt", 32'(wr_cnt), 32'd4);
        chk("t1_back_to_back", 32'(wr_cyc[3] - wr_cyc[0]), 32'd3);
        chk("t1_queue_empty", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 4; i++) chk("t1_readback", 32'(mem[16'h0200 + i]), 32'(img[i]));
        core_addr = 16'h1234;
        #1;
        chk("run_mux_addr", 32'(mem_addr), 32'h1234);
        core_addr = '0;

        // Same image with a stalling host
        clear_stats();
        load(4, img, gap);
        wait_end();
        chk("t2_done", 32'(done), 32'd1);
        repeat (3) @(negedge clk);
        chk("t2_wr_cnt", 32'(wr_cnt), 32'd4);
        chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("t2_trig_cnt", 32'(trig_cnt), 32'd1);

        // len == 0 skips straight to release
        clear_stats();
        @(posedge clk); #1;
        start = 1'b1; len = 16'd0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("len0_busy", 32'(busy), 32'd1);
        chk("len0_core_held", 32'(core_reset_n), 32'd0);
        @(posedge clk); #1;
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_trig", 32'(trigger_program), 32'd1);
        repeat (3) @(negedge clk);
        chk("len0_trig_cnt", 32'(trig_cnt), 32'd1);
        chk("len0_wr_cnt", 32'(wr_cnt), 32'd0);

        // Oversize length goes to error, then recovers
        clear_stats();
        @(posedge clk); #1;
        start = 1'b1; len = 16'd65025;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("err_flag", 32'(error), 32'd1);
        chk("err_core_held", 32'(core_reset_n), 32'd0);
        chk("err_wr_cnt", 32'(wr_cnt), 32'd0);
        load(1, '{8'h42}, none);
        wait_end();
        chk("recover_done", 32'(done), 32'd1);
        chk("recover_mem", 32'(mem[16'h0200]), 32'h42);

        // Reset mid-load after two bytes, then a clean 5-byte load
        sb_on = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; len = 16'd5;
        @(posedge clk); #1;
        start = 1'b0;
        host_valid = 1'b1; host_data = 8'hE0;
        @(posedge clk); #1;
        host_data = 8'hE1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        host_valid = 1'b0;
        #1;
        check_reset_outputs("midload_reset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        exp_q.delete();
        clear_stats();
        sb_on = 1'b1;
        load(5, img5, none);
        wait_end();
        chk("reload_done", 32'(done), 32'd1);
        chk("reload_wr_cnt", 32'(wr_cnt), 32'd5);
        for (int i = 0; i < 5; i++) chk("reload_readback", 32'(mem[16'h0200 + i]), 32'(img5[i]));

`ifdef BOOT_LOADER_VERIFY_EN
        // Corrupted readback must end in error with no trigger
        clear_stats();
        corrupt = 1'b1;
        load(4, img, none);
        wait_end();
        chk("verify_bad_error", 32'(error), 32'd1);
        repeat (3) @(negedge clk);
        chk("verify_bad_trig", 32'(trig_cnt), 32'd0);
        chk("verify_bad_core", 32'(core_reset_n), 32'd0);
        corrupt = 1'b0;
        clear_stats();
        load(4, img, none);
        wait_end();
        chk("verify_ok_done", 32'(done), 32'd1);
        repeat (3) @(negedge clk);
        chk("verify_ok_trig", 32'(trig_cnt), 32'd1);
`endif

        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
